// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with dual write ports, optional
// write-to-read bypass, hardwired zero register and a sequential bulk-clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                clr_done_q, clr_done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic wr0_ok;
    logic wr1_ok;
    logic clearing;

    // Writes only land while idle; the zero register silently swallows them.
    always_comb begin
        clearing = (state_q == CLEAR);
        wr0_ok   = wr0_en && (state_q == IDLE) && !((ZERO_REG != 0) && (wr0_addr == '0));
        wr1_ok   = wr1_en && (state_q == IDLE) && !((ZERO_REG != 0) && (wr1_addr == '0));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port 1 wins a same-address collision because it is checked first.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clearing && (idx_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end else if (wr1_ok && (wr1_addr == ADDR_W'(i))) begin
                mem_d[i] = wr1_data;
            end else if (wr0_ok && (wr0_addr == ADDR_W'(i))) begin
                mem_d[i] = wr0_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Zero register is applied last so it overrides any bypassed data.
        always_comb begin
            val = mem_q[addr];
            if ((BYPASS != 0) && (state_q == IDLE)) begin
                if (wr1_en && (wr1_addr == addr)) begin
                    val = wr1_data;
                end else if (wr0_en && (wr0_addr == addr)) begin
                    val = wr0_data;
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance (bypass, zero register) and
// a plain instance (no bypass, no zero register) share the same write/clear stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        wr0_en, wr1_en, clr_req;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        busy_a, done_a, busy_b, done_b;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] b0;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain arrays plus "sweep position" bookkeeping.
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    bit          sweeping;
    int          sweep_pos;
    bit          done_flag;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        sweeping  = 0;
        sweep_pos = 0;
        done_flag = 0;
    endfunction

    function automatic logic [31:0] read_a(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (!sweeping && wr1_en && wr1_addr == addr) return wr1_data;
        if (!sweeping && wr0_en && wr0_addr == addr) return wr0_data;
        return mem_a[addr];
    endfunction

    function automatic void model_edge();
        if (!sweeping) begin
            if (wr0_en) begin
                if (wr0_addr != 0) mem_a[wr0_addr] = wr0_data;
                mem_b[wr0_addr] = wr0_data;
            end
            if (wr1_en) begin
                if (wr1_addr != 0) mem_a[wr1_addr] = wr1_data;
                mem_b[wr1_addr] = wr1_data;
            end
            done_flag = 0;
            if (clr_req) begin
                sweeping  = 1;
                sweep_pos = 0;
            end
        end else begin
            mem_a[sweep_pos] = '0;
            mem_b[sweep_pos] = '0;
            sweep_pos++;
            done_flag = (sweep_pos == 32);
            if (sweep_pos == 32) sweeping = 0;
        end
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic apply_stimulus(input string tag);
        exp_t e;
        if (!rst_n) model_reset();
        e.tag  = tag;
        e.a0   = read_a(rd_addr_a[4:0]);
        e.a1   = read_a(rd_addr_a[9:5]);
        e.b0   = mem_b[rd_addr_b];
        e.busy = sweeping;
        e.done = done_flag;
        sb.push_back(e);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output({e.tag, " rdA0"}, rd_data_a[31:0], e.a0);
            check_output({e.tag, " rdA1"}, rd_data_a[63:32], e.a1);
            check_output({e.tag, " rdB0"}, rd_data_b, e.b0);
            check_output({e.tag, " busyA"}, {31'd0, busy_a}, {31'd0, e.busy});
            check_output({e.tag, " doneA"}, {31'd0, done_a}, {31'd0, e.done});
            check_output({e.tag, " busyB"}, {31'd0, busy_b}, {31'd0, e.busy});
            check_output({e.tag, " doneB"}, {31'd0, done_b}, {31'd0, e.done});
        end
    end

    task automatic idle_inputs();
        wr0_en = 0; wr1_en = 0; clr_req = 0;
        wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    endtask

    task automatic rand_reads();
        rd_addr_a = 10'($urandom);
        rd_addr_b = 5'($urandom);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            wr0_en = 1; wr0_addr = 5'(i);      wr0_data = 32'(i + 1);
            wr1_en = 1; wr1_addr = 5'(i + 16); wr1_data = 32'(i + 17);
            rd_addr_a = {5'(i + 16), 5'(i)};
            rd_addr_b = 5'(i);
            apply_stimulus("fill");
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        rd_addr_a = {5'd7, 5'd3};
        rd_addr_b = 5'd3;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) apply_stimulus("in_reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rd_addr_a = {5'(2 * i + 1), 5'(2 * i)};
            rd_addr_b = 5'(2 * i);
            apply_stimulus("after_reset");
        end

        // Same-address collision on both write ports.
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h12345678;
        rd_addr_a = {5'd5, 5'd5}; rd_addr_b = 5'd5;
        apply_stimulus("collide");
        idle_inputs();
        apply_stimulus("collide_after");

        // Write to the zero register.
        wr1_en = 1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        rd_addr_a = {5'd0, 5'd0}; rd_addr_b = 5'd0;
        apply_stimulus("zero_wr");
        idle_inputs();
        apply_stimulus("zero_after");

        for (int i = 0; i < 150; i++) begin
            wr0_en   = ($urandom_range(0, 1) == 1);
            wr1_en   = ($urandom_range(0, 1) == 1);
            wr0_addr = 5'($urandom_range(0, 7));
            wr1_addr = 5'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            clr_req  = ($urandom_range(0, 59) == 0);
            rd_addr_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd_addr_b = 5'($urandom_range(0, 7));
            apply_stimulus("random");
        end
        idle_inputs();
        while (sweeping) apply_stimulus("drain");

        // Full sweep with a dropped write and random writes inside it.
        fill_all();
        clr_req = 1;
        rd_addr_a = {5'd11, 5'd10}; rd_addr_b = 5'd11;
        apply_stimulus("clr_req");
        clr_req = 0;
        for (int c = 1; c <= 34; c++) begin
            idle_inputs();
            rd_addr_a = {5'd11, 5'd10};
            rd_addr_b = 5'd31;
            if (c == 3) begin
                wr0_en = 1; wr0_addr = 5'd31; wr0_data = 32'h0000AAAA;
                rd_addr_a = {5'd31, 5'd10};
            end else if (c > 3 && c < 30) begin
                wr1_en = 1; wr1_addr = 5'($urandom); wr1_data = $urandom;
                clr_req = ($urandom_range(0, 3) == 0);
            end
            apply_stimulus("sweep");
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = {5'(2 * i + 1), 5'(2 * i)};
            rd_addr_b = 5'(31 - i);
            apply_stimulus("post_sweep");
        end

        // Reset in the middle of a sweep.
        fill_all();
        clr_req = 1;
        apply_stimulus("clr_req2");
        clr_req = 0;
        for (int c = 1; c < 7; c++) begin
            rand_reads();
            apply_stimulus("sweep2");
        end
        rst_n = 1'b0;
        rand_reads();
        apply_stimulus("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_reads();
            apply_stimulus("post_abort");
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
